producto_a_bcd: RTL and testbench
=================================

Name: producto_a_bcd

Overview:
Sequential binary-to-BCD converter (shift-add-3, "double dabble") placed directly downstream of the shift-add multiplier. It takes the 17-bit Producto on a Start/Ready handshake and returns the packed BCD digits for the display/readout stage. One bit is processed per clock, so the area stays small and matches the multiplier's iterative style.

Parameters:
N_BITS, 17, width of binary input (matches Producto width)
N_DIGITS, 6, number of BCD output digits; must satisfy 10^N_DIGITS > 2^N_BITS - 1

Ports:
Clock  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-high reset
Start  input  1  request conversion; sampled on rising edge when not Busy
Binario  input  N_BITS  value to convert (connect to multiplier Producto); sampled only on accepted Start
Busy  output  1  high while conversion in progress
Ready  output  1  high when BCD holds a valid result; level, not pulse
BCD  output  4*N_DIGITS  packed BCD, digit 0 (units) in bits [3:0]

Behaviour:
- Reset (async, active-high): state=IDLE, Busy=0, Ready=0, BCD=0, internal shift/scratch/counter registers=0. Outputs are registered.
- States:
  - IDLE: wait for Start.
  - SHIFT: N_BITS iterations.
  - DONE: result held.
- Accept rule: Start=1 at a rising edge while state is IDLE or DONE.
  - Latch Binario into the shift register.
  - Clear the BCD scratch.
  - Set count=N_BITS-1.
  - Go to SHIFT, Busy=1, Ready=0.
  - BCD output keeps its previous value until the new result is written.
- SHIFT, each edge:
  - Each scratch digit >=5 gets +3 (all digits in parallel, combinational).
  - {scratch, shift} shift left 1, with the shift MSB entering scratch bit 0.
  - count decrements.
- Edge where count==0: the final adjusted+shifted scratch is written to BCD, state goes to DONE, Busy=0, Ready=1.
- Latency: Start accepted at edge k; Ready=1 and BCD valid after edge k+N_BITS (17 cycles default).
- DONE: Ready and BCD hold until the next accepted Start. Start held high in DONE restarts a conversion immediately.
- Start while Busy: ignored. No queuing, and Binario changes have no effect.
- Reset mid-conversion: immediate abort to reset values. The next Start behaves normally.
- Digit values never exceed 9 given the parameter constraint. No overflow output.

Optional Feature:
- Macro BCD_BLANK_EN.
- When defined, add output port Blank, width N_DIGITS, registered alongside BCD.
  - Blank[i]=1 when digit i and every higher digit are zero (leading-zero suppression).
  - Blank[0] is always 0.
  - Reset value is all-ones except bit 0.
  - Updated on the same edge as BCD.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset high 2 cycles, release; Binario=47945 (215*223), Start 1 cycle -> Busy for 17 cycles, then Ready=1, BCD=24'h047945, Busy=0.
2. From DONE, Binario=16915 (199*85), Start -> Ready drops the cycle after the accepted Start; 17 cycles later BCD=24'h016915. With BCD_BLANK_EN, Blank=6'b100000.
3. Binario=0 -> BCD=24'h000000. With BCD_BLANK_EN, Blank=6'b111110. Binario=131071 (max) -> BCD=24'h131071.
4. Start pulsed again at cycle 5 of a conversion with Binario changed to 12345 -> ignored; result is still the original value; Busy timing unchanged.
5. Reset asserted mid-conversion (cycle 8) -> Busy=0, Ready=0, BCD=0 immediately (asynchronous). Then Start with 65025 -> BCD=24'h065025 after 17 cycles.
6. Chained with the multiplier: multiplier Ready drives Start; Multiplicando=255, Multiplicador=255 -> BCD=24'h065025.

Source files
------------

// File: rtl/producto_a_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Define BCD_BLANK_EN to add the registered leading-zero Blank output.
module producto_a_bcd #(
  parameter int N_BITS   = 17,
  parameter int N_DIGITS = 6
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [N_BITS-1:0]       Binario,
  output logic                    Busy,
  output logic                    Ready,
  output logic [4*N_DIGITS-1:0]   BCD
`ifdef BCD_BLANK_EN
  ,
  output logic [N_DIGITS-1:0]     Blank
`endif
);

  localparam int BW = 4 * N_DIGITS;
  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]     scr_q, scr_d;
  logic [BW-1:0]     scr_adj, scr_nxt;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  // Add-3 on every digit >= 5 before the shift, so each digit carries out at 10.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    assign scr_adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ? scr_q[4*g +: 4] + 4'd3
                                                         : scr_q[4*g +: 4];
  end

  assign scr_nxt = {scr_adj[BW-2:0], shift_q[N_BITS-1]};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          shift_d = Binario;
          scr_d   = '0;
          cnt_d   = CW'(N_BITS - 1);
          state_d = SHIFT;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      SHIFT: begin
        scr_d   = scr_nxt;
        shift_d = {shift_q[N_BITS-2:0], 1'b0};
        if (cnt_q == '0) begin
          bcd_d   = scr_nxt;
          state_d = DONE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign Busy  = busy_q;
  assign Ready = ready_q;
  assign BCD   = bcd_q;

`ifdef BCD_BLANK_EN
  logic [N_DIGITS-1:0] blank_q, blank_nxt;
  logic                bcd_wr;

  // Digit i blanks only when it and all digits above it are zero; units never blank.
  assign blank_nxt[0] = 1'b0;
  for (genvar g = 1; g < N_DIGITS; g++) begin : g_blank
    assign blank_nxt[g] = ~|scr_nxt[BW-1:4*g];
  end

  assign bcd_wr = (state_q == SHIFT) && (cnt_q == '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)       blank_q <= {{(N_DIGITS-1){1'b1}}, 1'b0};
    else if (bcd_wr) blank_q <= blank_nxt;
  end

  assign Blank = blank_q;
`endif

endmodule

// File: tb/tb_producto_a_bcd.sv
// Bench for producto_a_bcd: directed plan cases plus randomized Start/Binario
// traffic, compared every cycle against a decimal-arithmetic reference model.
module tb_producto_a_bcd;
  localparam int N_BITS   = 17;
  localparam int N_DIGITS = 6;
  localparam int BW       = 4 * N_DIGITS;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              Start = 1'b0;
  logic [N_BITS-1:0] Binario = '0;
  logic              Busy, Ready;
  logic [BW-1:0]     BCD;
`ifdef BCD_BLANK_EN
  logic [N_DIGITS-1:0] Blank;
`endif

  producto_a_bcd #(.N_BITS(N_BITS), .N_DIGITS(N_DIGITS)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Binario(Binario),
    .Busy(Busy), .Ready(Ready), .BCD(BCD)
`ifdef BCD_BLANK_EN
    , .Blank(Blank)
`endif
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [N_DIGITS-1:0] blank_of(input int unsigned v);
    logic [N_DIGITS-1:0] b;
    int unsigned p;
    b = '0;
    p = 10;
    for (int i = 1; i < N_DIGITS; i++) begin
      b[i] = (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  // Reference model: busy for N_BITS edges after an accepted Start, then result held.
  logic              m_busy, m_ready;
  logic [BW-1:0]     m_bcd;
  logic [N_DIGITS-1:0] m_blank;
  int                m_left;
  int unsigned       m_val;
  int                m_done_cnt = 0;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_busy  = 1'b0;
      m_ready = 1'b0;
      m_bcd   = '0;
      m_blank = {{(N_DIGITS-1){1'b1}}, 1'b0};
      m_left  = 0;
    end else if (!m_busy && Start) begin
      m_busy  = 1'b1;
      m_ready = 1'b0;
      m_left  = N_BITS;
      m_val   = Binario;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy  = 1'b0;
        m_ready = 1'b1;
        m_bcd   = to_bcd(m_val);
        m_blank = blank_of(m_val);
        m_done_cnt++;
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge Clock) begin
    if (cmp_en && !Reset) begin
      chk("busy", Busy, m_busy);
      chk("ready", Ready, m_ready);
      chk("bcd", BCD, m_bcd);
`ifdef BCD_BLANK_EN
      chk("blank", Blank, m_blank);
`endif
    end
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic start_conv(input int unsigned v);
    Binario = N_BITS'(v);
    Start   = 1'b1;
    tick();
    Start   = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s: Ready never rose within 40 cycles", name);
    end
  endtask

  task automatic conv_expect(input string name, input int unsigned v, input logic [BW-1:0] exp);
    start_conv(v);
    chk({name, "_busy_after_start"}, Busy, 1'b1);
    repeat (N_BITS - 1) tick();
    chk({name, "_not_ready_early"}, Ready, 1'b0);
    tick();
    chk({name, "_ready"}, Ready, 1'b1);
    chk({name, "_bcd"}, BCD, exp);
  endtask

  initial begin
    chk("model_pin_47945", to_bcd(47945), 24'h047945);
    chk("model_pin_131071", to_bcd(131071), 24'h131071);
    chk("model_pin_blank_16915", blank_of(16915), 6'b100000);
    chk("model_pin_blank_0", blank_of(0), 6'b111110);

    repeat (2) @(posedge Clock);
    #1;
    chk("reset_busy", Busy, 1'b0);
    chk("reset_ready", Ready, 1'b0);
    chk("reset_bcd", BCD, 24'h0);
`ifdef BCD_BLANK_EN
    chk("reset_blank", Blank, 6'b111110);
`endif
    Reset  = 1'b0;
    cmp_en = 1'b1;
    tick();

    conv_expect("t1", 47945, 24'h047945);
    chk("t1_busy_low", Busy, 1'b0);
    tick();

    start_conv(16915);
    chk("t2_ready_drop", Ready, 1'b0);
    chk("t2_bcd_held", BCD, 24'h047945);
    wait_ready("t2_wait");
    chk("t2_bcd", BCD, 24'h016915);
`ifdef BCD_BLANK_EN
    chk("t2_blank", Blank, 6'b100000);
`endif

    conv_expect("t3_zero", 0, 24'h000000);
`ifdef BCD_BLANK_EN
    chk("t3_blank", Blank, 6'b111110);
`endif
    conv_expect("t3_max", 131071, 24'h131071);

    // Start retriggered mid-conversion with a different operand must be ignored.
    start_conv(47945);
    repeat (4) tick();
    Binario = 17'd12345;
    Start   = 1'b1;
    tick();
    Start   = 1'b0;
    repeat (N_BITS - 6) tick();
    chk("t4_still_busy", Busy, 1'b1);
    tick();
    chk("t4_ready", Ready, 1'b1);
    chk("t4_bcd", BCD, 24'h047945);

    // Asynchronous abort in the middle of a cycle.
    start_conv(99999);
    repeat (7) tick();
    #2 Reset = 1'b1;
    #1;
    chk("t5_rst_busy", Busy, 1'b0);
    chk("t5_rst_ready", Ready, 1'b0);
    chk("t5_rst_bcd", BCD, 24'h0);
    tick();
    Reset = 1'b0;
    tick();
    conv_expect("t5", 65025, 24'h065025);

    // Operand as produced by the multiplier for 255*255.
    conv_expect("t6", 255 * 255, 24'h065025);

    // Randomized traffic: Start held/pulsed at random, operands biased to extremes.
    for (int c = 0; c < 1500; c++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      Binario = (sel == 0) ? 17'd0 : (sel == 1) ? 17'h1FFFF : N_BITS'($urandom);
      Start   = ($urandom_range(0, 3) == 0);
      tick();
    end
    Start = 1'b0;
    repeat (N_BITS + 2) tick();
    checks++;
    if (m_done_cnt < 30) begin
      failures++;
      $display("FAIL random_coverage: conversions %0d expected at least 30", m_done_cnt);
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
